// File: rtl/ecc_error_monitor.sv
// rtl/ecc_error_monitor.sv - windowed ECC error statistics and protection-level recommendation
//
// Purpose: counts decoded words in fixed windows and tallies their errors. At each
// window close it steps a LOW/MED/HIGH protection-level recommendation with hysteresis
// and sets a sticky alarm. It also keeps saturating lifetime error totals.
//
// Ports:
//   clk, rst (async, active-high), clear (sync soft clear)
//   sample_valid, error_detected, error_corrected : per-word decode result
//   level[1:0], level_change    : recommendation and one-cycle change pulse
//   window_done, window_err_count : window close pulse and its error count
//   total_errors[31:0], total_uncorrected[15:0] : saturating lifetime totals
//   alarm                        : sticky, raise condition seen while already HIGH
module ecc_error_monitor #(
    parameter int WINDOW_LEN   = 64,
    parameter int CNT_WIDTH    = 7,
    parameter int RAISE_THRESH = 4,
    parameter int LOWER_THRESH = 1,
    parameter int HOLD_WINDOWS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 sample_valid,
    input  logic                 error_detected,
    input  logic                 error_corrected,
    output logic [1:0]           level,
    output logic                 level_change,
    output logic                 window_done,
    output logic [CNT_WIDTH-1:0] window_err_count,
    output logic [31:0]          total_errors,
    output logic [15:0]          total_uncorrected,
    output logic                 alarm
);

    localparam int CALM_W = $clog2(HOLD_WINDOWS + 1);

    localparam logic [CNT_WIDTH-1:0] LAST_SAMPLE = CNT_WIDTH'(WINDOW_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] RAISE_C     = CNT_WIDTH'(RAISE_THRESH);
    localparam logic [CNT_WIDTH-1:0] LOWER_C     = CNT_WIDTH'(LOWER_THRESH);
    localparam logic [CALM_W-1:0]    HOLD_C      = CALM_W'(HOLD_WINDOWS);
    localparam logic [CALM_W-1:0]    HOLD_M1     = CALM_W'(HOLD_WINDOWS - 1);

    typedef enum logic [1:0] {
        LVL_LOW  = 2'd0,
        LVL_MED  = 2'd1,
        LVL_HIGH = 2'd2
    } level_t;

    level_t                 level_q, level_d;
    logic                   level_change_q, level_change_d;
    logic                   window_done_q, window_done_d;
    logic [CNT_WIDTH-1:0]   window_err_count_q, window_err_count_d;
    logic [CNT_WIDTH-1:0]   sample_cnt_q, sample_cnt_d;
    logic [CNT_WIDTH-1:0]   err_acc_q, err_acc_d;
    logic [CALM_W-1:0]      calm_q, calm_d;
    logic [31:0]            tot_err_q, tot_err_d;
    logic [15:0]            tot_unc_q, tot_unc_d;
    logic                   alarm_q, alarm_d;

    logic                   err_bit;
    logic                   unc_bit;
    logic [CNT_WIDTH-1:0]   close_cnt;

    always_comb begin
        level_d            = level_q;
        level_change_d     = 1'b0;
        window_done_d      = 1'b0;
        window_err_count_d = window_err_count_q;
        sample_cnt_d       = sample_cnt_q;
        err_acc_d          = err_acc_q;
        calm_d             = calm_q;
        tot_err_d          = tot_err_q;
        tot_unc_d          = tot_unc_q;
        alarm_d            = alarm_q;

        err_bit   = error_detected;
        unc_bit   = error_detected & ~error_corrected;
        // Count including the current word; this is the closing count C at window close.
        close_cnt = err_acc_q + CNT_WIDTH'(err_bit);

        if (clear) begin
            level_d            = LVL_LOW;
            window_err_count_d = '0;
            sample_cnt_d       = '0;
            err_acc_d          = '0;
            calm_d             = '0;
            tot_err_d          = '0;
            tot_unc_d          = '0;
            alarm_d            = 1'b0;
        end else if (sample_valid) begin
            if (err_bit && (tot_err_q != '1)) tot_err_d = tot_err_q + 32'd1;
            if (unc_bit && (tot_unc_q != '1)) tot_unc_d = tot_unc_q + 16'd1;

            if (sample_cnt_q == LAST_SAMPLE) begin
                sample_cnt_d       = '0;
                err_acc_d          = '0;
                window_err_count_d = close_cnt;
                window_done_d      = 1'b1;

                if (close_cnt >= RAISE_C) begin
                    calm_d = '0;
                    if (level_q != LVL_HIGH) begin
                        level_d        = level_t'(level_q + 2'd1);
                        level_change_d = 1'b1;
                    end else begin
                        alarm_d = 1'b1;
                    end
                end else if (close_cnt <= LOWER_C) begin
                    // calm_q + 1 reaches the hold count; at LOW it parks there.
                    if (calm_q >= HOLD_M1) begin
                        if (level_q != LVL_LOW) begin
                            level_d        = level_t'(level_q - 2'd1);
                            level_change_d = 1'b1;
                            calm_d         = '0;
                        end else begin
                            calm_d = HOLD_C;
                        end
                    end else begin
                        calm_d = calm_q + CALM_W'(1);
                    end
                end else begin
                    calm_d = '0;
                end
            end else begin
                sample_cnt_d = sample_cnt_q + CNT_WIDTH'(1);
                err_acc_d    = close_cnt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q            <= LVL_LOW;
            level_change_q     <= 1'b0;
            window_done_q      <= 1'b0;
            window_err_count_q <= '0;
            sample_cnt_q       <= '0;
            err_acc_q          <= '0;
            calm_q             <= '0;
            tot_err_q          <= '0;
            tot_unc_q          <= '0;
            alarm_q            <= 1'b0;
        end else begin
            level_q            <= level_d;
            level_change_q     <= level_change_d;
            window_done_q      <= window_done_d;
            window_err_count_q <= window_err_count_d;
            sample_cnt_q       <= sample_cnt_d;
            err_acc_q          <= err_acc_d;
            calm_q             <= calm_d;
            tot_err_q          <= tot_err_d;
            tot_unc_q          <= tot_unc_d;
            alarm_q            <= alarm_d;
        end
    end

    assign level             = level_q;
    assign level_change      = level_change_q;
    assign window_done       = window_done_q;
    assign window_err_count  = window_err_count_q;
    assign total_errors      = tot_err_q;
    assign total_uncorrected = tot_unc_q;
    assign alarm             = alarm_q;

endmodule

// File: tb/tb_ecc_error_monitor.sv
// tb/tb_ecc_error_monitor.sv - directed self-checking bench for ecc_error_monitor
module tb_ecc_error_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        sample_valid = 1'b0;
    logic        error_detected = 1'b0;
    logic        error_corrected = 1'b0;
    logic [1:0]  level;
    logic        level_change;
    logic        window_done;
    logic [6:0]  window_err_count;
    logic [31:0] total_errors;
    logic [15:0] total_uncorrected;
    logic        alarm;

    int checks = 0;
    int failures = 0;

    ecc_error_monitor #(
        .WINDOW_LEN  (8),
        .CNT_WIDTH   (7),
        .RAISE_THRESH(3),
        .LOWER_THRESH(0),
        .HOLD_WINDOWS(2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .clear            (clear),
        .sample_valid     (sample_valid),
        .error_detected   (error_detected),
        .error_corrected  (error_corrected),
        .level            (level),
        .level_change     (level_change),
        .window_done      (window_done),
        .window_err_count (window_err_count),
        .total_errors     (total_errors),
        .total_uncorrected(total_uncorrected),
        .alarm            (alarm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic v, input logic det, input logic cor);
        @(negedge clk);
        sample_valid    = v;
        error_detected  = det;
        error_corrected = cor;
    endtask

    task automatic idle();
        @(negedge clk);
        sample_valid    = 1'b0;
        error_detected  = 1'b0;
        error_corrected = 1'b0;
    endtask

    // mask[i] = error on sample i+1; returns at the negedge where window_done is visible
    task automatic run_window(input logic [7:0] mask);
        for (int i = 0; i < 8; i++) send(1'b1, mask[i], 1'b1);
        idle();
    endtask

    task automatic check_win(input string tag, input int cnt, input int lvl, input int lc,
                             input int alm, input int tot);
        check({tag, "_done"}, 32'(window_done), 32'd1);
        check({tag, "_cnt"}, 32'(window_err_count), 32'(cnt));
        check({tag, "_level"}, 32'(level), 32'(lvl));
        check({tag, "_lchg"}, 32'(level_change), 32'(lc));
        check({tag, "_alarm"}, 32'(alarm), 32'(alm));
        check({tag, "_tot"}, total_errors, 32'(tot));
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_level", 32'(level), 32'd0);
        check("rst_done", 32'(window_done), 32'd0);
        check("rst_tot", total_errors, 32'd0);
        rst = 1'b0;

        // Test 1: async reset mid-window
        send(1'b1, 1'b1, 1'b1);
        send(1'b1, 1'b1, 1'b0);
        send(1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b0, 1'b0);
        idle();
        check("t1_pre_tot", total_errors, 32'd2);
        check("t1_pre_unc", 32'(total_uncorrected), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t1_async_tot", total_errors, 32'd0);
        check("t1_async_unc", 32'(total_uncorrected), 32'd0);
        check("t1_async_level", 32'(level), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) send(1'b1, 1'b0, 1'b0);
        idle();
        check("t1_seven_nodone", 32'(window_done), 32'd0);
        send(1'b1, 1'b0, 1'b0);
        idle();
        check_win("t1_win", 0, 0, 0, 0, 0);

        // Test 2: errors on samples 1,4,8 -> raise to MED
        run_window(8'b1000_1001);
        check_win("t2_win", 3, 1, 1, 0, 3);
        idle();
        check("t2_lchg_clear", 32'(level_change), 32'd0);
        check("t2_done_clear", 32'(window_done), 32'd0);

        // Test 3: hysteresis on lowering
        run_window(8'h00);
        check_win("t3_calm1", 0, 1, 0, 0, 3);
        run_window(8'h00);
        check_win("t3_calm2", 0, 0, 1, 0, 3);
        run_window(8'b0000_0111);
        check_win("t3_raise", 3, 1, 1, 0, 6);
        run_window(8'h00);
        check_win("t3_calmA", 0, 1, 0, 0, 6);
        run_window(8'b0001_0000);
        check_win("t3_one", 1, 1, 0, 0, 7);
        run_window(8'h00);
        check_win("t3_calmB", 0, 1, 0, 0, 7);
        run_window(8'h00);
        check_win("t3_calmC", 0, 0, 1, 0, 7);

        // Test 4: climb to HIGH, then alarm
        run_window(8'b0010_0101);
        check_win("t4_w1", 3, 1, 1, 0, 10);
        run_window(8'b1110_0000);
        check_win("t4_w2", 3, 2, 1, 0, 13);
        run_window(8'b0101_0100);
        check_win("t4_w3", 3, 2, 0, 1, 16);
        run_window(8'h00);
        check_win("t4_calm1", 0, 2, 0, 1, 16);
        run_window(8'h00);
        check_win("t4_calm2", 0, 1, 1, 1, 16);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("t4_clr_alarm", 32'(alarm), 32'd0);
        check("t4_clr_level", 32'(level), 32'd0);
        check("t4_clr_tot", total_errors, 32'd0);

        // Test 5: corrected vs uncorrected, invalid samples ignored
        for (int i = 0; i < 5; i++) send(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) send(1'b1, 1'b1, 1'b0);
        idle();
        check("t5_tot", total_errors, 32'd8);
        check("t5_unc", 32'(total_uncorrected), 32'd3);
        check("t5_cnt", 32'(window_err_count), 32'd8);
        check("t5_level", 32'(level), 32'd1);
        for (int i = 0; i < 3; i++) send(1'b0, 1'b1, 1'b0);
        send(1'b1, 1'b0, 1'b1);
        idle();
        check("t5_inv_tot", total_errors, 32'd8);
        check("t5_inv_unc", 32'(total_uncorrected), 32'd3);
        check("t5_inv_done", 32'(window_done), 32'd0);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;

        // Test 6: clear coincident with the closing sample
        for (int i = 0; i < 7; i++) send(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        sample_valid   = 1'b1;
        error_detected = 1'b1;
        clear          = 1'b1;
        @(negedge clk);
        clear        = 1'b0;
        sample_valid = 1'b0;
        check("t6_clr_done", 32'(window_done), 32'd0);
        check("t6_clr_tot", total_errors, 32'd0);
        check("t6_clr_unc", 32'(total_uncorrected), 32'd0);
        check("t6_clr_level", 32'(level), 32'd0);
        for (int i = 0; i < 7; i++) send(1'b1, 1'b0, 1'b0);
        idle();
        check("t6_fresh_nodone", 32'(window_done), 32'd0);
        send(1'b1, 1'b0, 1'b0);
        idle();
        check("t6_fresh_done", 32'(window_done), 32'd1);

        // Saturation of total_uncorrected
        force dut.tot_unc_q = 16'hFFFD;
        #1 release dut.tot_unc_q;
        for (int i = 0; i < 3; i++) send(1'b1, 1'b1, 1'b0);
        idle();
        check("t6_sat", 32'(total_uncorrected), 32'h0000FFFF);
        send(1'b1, 1'b1, 1'b0);
        idle();
        check("t6_sat_hold", 32'(total_uncorrected), 32'h0000FFFF);
        check("t6_sat_tot", total_errors, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
